// File: rtl/fft_ctrl_pkg.sv
// ==========================================================
// fft_ctrl_pkg : shared types and constants for the FFT stage scheduler
// Revision: 1.0
// ==========================================================
`default_nettype none

package fft_ctrl_pkg;

  localparam int SLOTS   = 4;
  localparam int SEL_W   = 2;
  localparam int STAGE_W = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic [SLOTS-1:0] slot_onehot(input logic [SEL_W-1:0] slot);
    return {{(SLOTS-1){1'b0}}, 1'b1} << slot;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_stage_sched_if.sv
// ==========================================================
// fft_stage_sched_if : control/strobe bundle between scheduler and datapath
// Revision: 1.0
// ==========================================================
`default_nettype none

interface fft_stage_sched_if;
  import fft_ctrl_pkg::*;

  logic               start;
  logic               abort;
  logic [SEL_W-1:0]   mac_sel;
  logic [SLOTS-1:0]   cap_en;
  logic [STAGE_W-1:0] stage;
  logic               rd_bank;
  logic               wr_bank;
  logic               wr_en;
  logic               busy;
  logic               done;

  modport master (
    input  start, abort,
    output mac_sel, cap_en, stage, rd_bank, wr_bank, wr_en, busy, done
  );

  modport slave (
    output start, abort,
    input  mac_sel, cap_en, stage, rd_bank, wr_bank, wr_en, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/fft_cap_pipe.sv
// ==========================================================
// fft_cap_pipe : DEPTH-cycle delay of {valid, slot} decoded to a one-hot capture strobe
// Revision: 1.0
// ==========================================================
`default_nettype none

module fft_cap_pipe
  import fft_ctrl_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             clear,
  input  wire logic             in_valid,
  input  wire logic [SEL_W-1:0] in_slot,
  output logic      [SLOTS-1:0] cap_en
);

  localparam int EW = SEL_W + 1;

  logic [DEPTH*EW-1:0] pipe;
  logic [EW-1:0]       tail;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)     pipe <= '0;
        else if (clear) pipe <= '0;
        else            pipe <= {in_valid, in_slot};
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)     pipe <= '0;
        else if (clear) pipe <= '0;
        else            pipe <= {pipe[(DEPTH-1)*EW-1:0], in_valid, in_slot};
      end
    end
  endgenerate

  assign tail   = pipe[DEPTH*EW-1 -: EW];
  assign cap_en = tail[EW-1] ? slot_onehot(tail[SEL_W-1:0]) : '0;

endmodule

`default_nettype wire

// File: rtl/fft_stage_sched.sv
// ==========================================================
// fft_stage_sched : sequences slot issue, MAC drain and ping-pong commit per butterfly stage
// Revision: 1.0
// ==========================================================
`default_nettype none

module fft_stage_sched
  import fft_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int MAC_LAT    = 1
) (
  input wire logic            clk,
  input wire logic            reset,
  fft_stage_sched_if.master   bus
);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [1:0]         LAST_DRAIN = 2'(MAC_LAT - 1);
  localparam logic [SEL_W-1:0]   LAST_SLOT  = SEL_W'(SLOTS - 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   slot_cnt, slot_nxt;
  logic [STAGE_W-1:0] stage_cnt, stage_nxt;
  logic [1:0]         drain_cnt, drain_nxt;
  logic               rd_bank, bank_nxt;
  logic               issue_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      stage_cnt <= '0;
      drain_cnt <= '0;
      rd_bank   <= 1'b0;
    end else begin
      state     <= state_nxt;
      slot_cnt  <= slot_nxt;
      stage_cnt <= stage_nxt;
      drain_cnt <= drain_nxt;
      rd_bank   <= bank_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_cnt;
    stage_nxt = stage_cnt;
    drain_nxt = drain_cnt;
    bank_nxt  = rd_bank;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          slot_nxt  = '0;
          stage_nxt = '0;
          bank_nxt  = 1'b0;
        end
      end
      RUN: begin
        slot_nxt = slot_cnt + 1'b1;
        if (slot_cnt == LAST_SLOT) begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end
      end
      DRAIN: begin
        drain_nxt = drain_cnt + 1'b1;
        if (drain_cnt == LAST_DRAIN) state_nxt = COMMIT;
      end
      COMMIT: begin
        bank_nxt = ~rd_bank;
        if (stage_cnt == LAST_STAGE) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
          stage_nxt = stage_cnt + 1'b1;
          slot_nxt  = '0;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort discards any pending commit, so stage and bank keep their current values.
    if (bus.abort) begin
      state_nxt = IDLE;
      slot_nxt  = '0;
      drain_nxt = '0;
      stage_nxt = stage_cnt;
      bank_nxt  = rd_bank;
    end
  end

  assign issue_valid = (state == RUN);

  fft_cap_pipe #(.DEPTH(MAC_LAT)) u_cap_pipe (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.abort),
    .in_valid (issue_valid),
    .in_slot  (slot_cnt),
    .cap_en   (bus.cap_en)
  );

  assign bus.mac_sel = issue_valid ? slot_cnt : '0;
  assign bus.stage   = stage_cnt;
  assign bus.rd_bank = rd_bank;
  assign bus.wr_bank = ~rd_bank;
  assign bus.wr_en   = (state == COMMIT);
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_fft_stage_sched.sv
// ==========================================================
// tb_fft_stage_sched : self-checking bench, two instances (3 stages/lat 1 and 1 stage/lat 3)
// Revision: 1.0
// ==========================================================
`default_nettype none

module tb_fft_stage_sched;
  import fft_ctrl_pkg::*;

  typedef struct packed {
    logic [1:0] mac_sel;
    logic [3:0] cap_en;
    logic [1:0] stage;
    logic       rd_bank;
    logic       wr_bank;
    logic       wr_en;
    logic       busy;
    logic       done;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_n;
  logic  start_v [2];
  logic  abort_v [2];
  outs_t got [2];
  outs_t last_idle [2];
  int    n_checks = 0;
  int    n_fail   = 0;

  fft_stage_sched_if bus0 ();
  fft_stage_sched_if bus1 ();

  assign bus0.start = start_v[0];
  assign bus0.abort = abort_v[0];
  assign bus1.start = start_v[1];
  assign bus1.abort = abort_v[1];

  fft_stage_sched #(.NUM_STAGES(3), .MAC_LAT(1)) dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
  fft_stage_sched #(.NUM_STAGES(1), .MAC_LAT(3)) dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

  assign got[0] = {bus0.mac_sel, bus0.cap_en, bus0.stage, bus0.rd_bank, bus0.wr_bank,
                   bus0.wr_en, bus0.busy, bus0.done};
  assign got[1] = {bus1.mac_sel, bus1.cap_en, bus1.stage, bus1.rd_bank, bus1.wr_bank,
                   bus1.wr_en, bus1.busy, bus1.done};

  function automatic int ns_of(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic int ml_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic outs_t reset_outs();
    outs_t o = '0;
    o.wr_bank = 1'b1;
    return o;
  endfunction

  // Expected outputs k cycles after the start edge, from the stage period and offsets.
  function automatic outs_t model_run(input int ns, input int ml, input int k);
    outs_t o = '0;
    int p = 5 + ml;
    int st, off;
    if (k <= ns * p) begin
      st = (k - 1) / p;
      off = (k - 1) % p;
      o.stage   = 2'(st);
      o.rd_bank = 1'(st % 2);
      o.busy    = 1'b1;
      if (off < 4) o.mac_sel = 2'(off);
      if (off >= ml && off < ml + 4) o.cap_en = 4'(1 << (off - ml));
      o.wr_en = (off == 4 + ml);
    end else begin
      o.stage   = 2'(ns - 1);
      o.rd_bank = 1'(ns % 2);
      o.busy    = (k == ns * p + 1);
      o.done    = (k == ns * p + 1);
    end
    o.wr_bank = ~o.rd_bank;
    return o;
  endfunction

  task automatic run_traced(input int d, input string name, input int abort_at,
                            input int reset_at, input logic [31:0] smask,
                            output int n_wr, output int n_done);
    int    ns = ns_of(d);
    int    ml = ml_of(d);
    int    p = 5 + ml;
    int    len = ns * p + 4;
    outs_t exp_o;
    outs_t idle = '0;
    bit    aborted = 1'b0;
    n_wr = 0;
    n_done = 0;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    for (int k = 1; k <= len; k++) begin
      exp_o = aborted ? idle : model_run(ns, ml, k);
      n_checks++;
      if (got[d] !== exp_o) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b required %b", name, k, got[d], exp_o);
      end
      n_wr   += int'(got[d].wr_en);
      n_done += int'(got[d].done);
      if (k == abort_at) begin
        aborted = 1'b1;
        idle = '0;
        idle.stage   = exp_o.stage;
        idle.rd_bank = exp_o.rd_bank;
        idle.wr_bank = ~exp_o.rd_bank;
      end
      abort_v[d] = (k == abort_at);
      start_v[d] = !aborted && (k <= ns * p + 1) && (k < 32) && smask[k];
      if (k == reset_at) begin
        start_v[d] = 1'b0;
        abort_v[d] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (got[d] !== reset_outs()) begin
          n_fail++;
          $display("FAIL %s async_reset: got %b required %b", name, got[d], reset_outs());
        end
        @(posedge clk); #1;
        n_checks++;
        if (got[d] !== reset_outs()) begin
          n_fail++;
          $display("FAIL %s reset_held: got %b required %b", name, got[d], reset_outs());
        end
        rst_n = 1'b1;
        last_idle[0] = reset_outs();
        last_idle[1] = reset_outs();
        return;
      end
      @(posedge clk); #1;
    end
    abort_v[d] = 1'b0;
    start_v[d] = 1'b0;
    last_idle[d] = aborted ? idle : model_run(ns, ml, len);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    abort_v[0] = 1'b0; abort_v[1] = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (got[d] !== reset_outs()) begin
        n_fail++;
        $display("FAIL reset_initial dut%0d: got %b required %b", d, got[d], reset_outs());
      end
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (got[d] !== reset_outs()) begin
        n_fail++;
        $display("FAIL reset_release dut%0d: got %b required %b", d, got[d], reset_outs());
      end
      last_idle[d] = reset_outs();
    end
  endtask

  task automatic test_default_run();
    int wr, dn;
    run_traced(0, "default_run", 0, 0, 32'h0, wr, dn);
    n_checks++;
    if (wr != 3 || dn != 1) begin
      n_fail++;
      $display("FAIL default_run pulses: got wr=%0d done=%0d required wr=3 done=1", wr, dn);
    end
  endtask

  task automatic test_lat3_run();
    int wr, dn;
    run_traced(1, "lat3_run", 0, 0, 32'h0, wr, dn);
    n_checks++;
    if (wr != 1 || dn != 1) begin
      n_fail++;
      $display("FAIL lat3_run pulses: got wr=%0d done=%0d required wr=1 done=1", wr, dn);
    end
  endtask

  task automatic test_abort();
    int wr, dn;
    run_traced(0, "abort_c3", 3, 0, 32'h0, wr, dn);
    n_checks++;
    if (wr != 0 || dn != 0) begin
      n_fail++;
      $display("FAIL abort_c3 pulses: got wr=%0d done=%0d required wr=0 done=0", wr, dn);
    end
    test_default_run();
  endtask

  task automatic test_restart_ignored();
    int wr, dn;
    run_traced(0, "restart_ignored", 0, 0, (32'h1 << 5) | (32'h1 << 12), wr, dn);
    n_checks++;
    if (wr != 3 || dn != 1) begin
      n_fail++;
      $display("FAIL restart_ignored pulses: got wr=%0d done=%0d required wr=3 done=1", wr, dn);
    end
  endtask

  task automatic test_reset_midrun();
    int wr, dn;
    run_traced(0, "reset_c10", 0, 10, 32'h0, wr, dn);
    test_default_run();
  endtask

  task automatic test_abort_start_idle(input int d);
    start_v[d] = 1'b1;
    abort_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    abort_v[d] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (got[d] !== last_idle[d]) begin
        n_fail++;
        $display("FAIL abort_start_idle dut%0d cycle %0d: got %b required %b",
                 d, k, got[d], last_idle[d]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int wr, dn, d, mode, lim;
    for (int i = 0; i < 24; i++) begin
      d = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 3));
      lim = ns_of(d) * (5 + ml_of(d)) + 1;
      case (mode)
        0: run_traced(d, "rand_run", 0, 0, $urandom, wr, dn);
        1: run_traced(d, "rand_abort", int'($urandom_range(1, lim)), 0, $urandom, wr, dn);
        2: run_traced(d, "rand_reset", 0, int'($urandom_range(1, lim)), $urandom, wr, dn);
        default: test_abort_start_idle(d);
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_lat3_run();
    test_abort();
    test_restart_ignored();
    test_reset_midrun();
    test_abort_start_idle(0);
    test_abort_start_idle(1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
